am_indx_engine: RTL and testbench
=================================

AM_INDX_ENGINE -- requirements
Module: am_indx_engine

Interface
REQ-001 SHALL have parameter PW, default 12, meaning width of pp_t2b/pp_b2t.
REQ-002 SHALL have parameter QW, default 8, meaning width of indx_cal.
REQ-003 SHALL have parameter SCALE, default 100, meaning numerator multiplier; legal range 1..255.
REQ-004 SHALL have parameter MODE, default 0, meaning 0 = unsigned clamp, 1 = signed magnitude.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, meaning reset; synchronous, active-high.
REQ-007 SHALL have port pls, input, 1 bit, meaning clock enable; an edge with pls=1 is an "enabled edge".
REQ-008 SHALL have port start, input, 1 bit, meaning request a calculation.
REQ-009 SHALL have port up_dni, input, 1 bit, meaning direction: 1 = t2b-b2t, 0 = b2t-t2b.
REQ-010 SHALL have ports pp_t2b and pp_b2t, input, PW bits each, meaning peak samples.
REQ-011 SHALL have port busy, output, 1 bit, meaning high in any state other than IDLE.
REQ-012 SHALL have port indx_dn, output, 1 bit, meaning one-clk done pulse.
REQ-013 SHALL have port indx_cal, output, QW bits, meaning registered index magnitude.
REQ-014 SHALL have port indx_neg, output, 1 bit, meaning sign of last result (MODE 1 only, else 0).
REQ-015 SHALL have port div_err, output, 1 bit, meaning last result had zero denominator.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, DIV, DONE; IDLE/LOAD/DIV advance only on enabled edges.
REQ-017 IDLE->LOAD SHALL occur on an enabled edge with start=1; start SHALL be ignored in all other states.
REQ-018 In LOAD, operands SHALL be captured: den = pp_t2b+pp_b2t (PW+1 bits, no saturation).
REQ-019 In LOAD, d = selected difference per up_dni (PW+1-bit signed); neg = (d<0).
REQ-020 MODE 0 with neg SHALL force magnitude 0 and indx_neg 0; MODE 1 SHALL use |d| and record neg.
REQ-021 Numerator SHALL be |d|*SCALE, NW = PW+8 bits, exact; LOAD->DIV on the next enabled edge.
REQ-022 DIV SHALL be a restoring divider producing one quotient bit per enabled edge, MSB first, exactly NW steps, then ->DONE.
REQ-023 On entry to DONE, indx_cal SHALL load min(quotient, 2^QW-1).
REQ-024 On entry to DONE, indx_neg and div_err SHALL be updated together with indx_cal.
REQ-025 den=0 SHALL give quotient 0, div_err=1, indx_neg=0, with the same latency as a normal calculation.
REQ-026 indx_dn SHALL be 1 only while in DONE; DONE->IDLE on the next clk edge regardless of pls.
REQ-027 Latency: with pls tied 1 and start accepted at edge N, indx_dn SHALL be high between edges N+NW+1 and N+NW+2 (N+21 for PW=12).
REQ-028 pls=0 SHALL freeze state, step counter and partial remainder; it SHALL NOT corrupt the result.
REQ-029 indx_cal/indx_neg/div_err SHALL hold the last result until the next DONE; input changes after LOAD SHALL have no effect.
REQ-030 start held high continuously SHALL launch a new calculation on the first enabled edge in IDLE after DONE (back-to-back).

Reset
REQ-031 rst=1 at a clk edge SHALL force IDLE regardless of pls, in any state including mid-DIV.
REQ-032 On reset, busy, indx_dn, indx_cal, indx_neg and div_err SHALL all be 0, and the step counter and remainder SHALL clear.
REQ-033 An in-flight calculation interrupted by rst SHALL NOT produce indx_dn.

Verification
REQ-034 Unsigned case: MODE0, pls=1, t2b=300, b2t=100, up_dni=1, start pulse -> indx_dn at N+21, indx_cal=50, indx_neg=0, div_err=0.
REQ-035 Sign handling: t2b=100, b2t=300, up_dni=1 -> MODE0: indx_cal=0, indx_neg=0; MODE1: indx_cal=50, indx_neg=1.
REQ-036 Zero denominator and saturation: t2b=b2t=0 -> indx_cal=0, div_err=1; QW=6, t2b=4095, b2t=0 -> quotient 100 saturates to indx_cal=63.
REQ-037 Enable gating: pls toggling 1,0,1,0... -> same result as the first case, with indx_dn after 21 enabled edges, and busy high throughout.
REQ-038 Reset mid-operation: rst=1 for one edge at the 10th DIV step -> busy=0 and outputs 0 next cycle, no indx_dn; a following start yields a correct result.

Source files
------------

// File: rtl/am_indx_engine.sv
// Index engine: computes |pp_t2b - pp_b2t| * SCALE / (pp_t2b + pp_b2t) with a
// bit-serial restoring divider advanced by the pls clock enable.
module am_indx_engine #(
    parameter int PW    = 12,
    parameter int QW    = 8,
    parameter int SCALE = 100,
    parameter int MODE  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pls,
    input  logic          start,
    input  logic          up_dni,
    input  logic [PW-1:0] pp_t2b,
    input  logic [PW-1:0] pp_b2t,
    output logic          busy,
    output logic          indx_dn,
    output logic [QW-1:0] indx_cal,
    output logic          indx_neg,
    output logic          div_err
);

    localparam int NW = PW + 8;
    localparam int RW = PW + 2;
    localparam int SW = $clog2(NW + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    state_t         state_reg, state_next;
    logic [SW-1:0]  step_reg;
    logic [PW:0]    den_reg;
    logic [RW-1:0]  rem_reg;
    logic [NW-1:0]  quo_reg;
    logic           neg_reg;
    logic [QW-1:0]  indx_cal_reg;
    logic           indx_neg_reg;
    logic           div_err_reg;

    // Operand preparation, sampled on the enabled edge that leaves LOAD
    logic [PW:0]    den_load;
    logic [PW:0]    diff;
    logic [PW:0]    mag;
    logic [PW:0]    mag_sel;
    logic [NW-1:0]  num_load;
    logic           neg_load;

    assign den_load = {1'b0, pp_t2b} + {1'b0, pp_b2t};
    assign diff     = up_dni ? ({1'b0, pp_t2b} - {1'b0, pp_b2t})
                             : ({1'b0, pp_b2t} - {1'b0, pp_t2b});
    assign mag      = diff[PW] ? -diff : diff;
    // Unsigned mode clamps a negative difference to a zero numerator
    assign mag_sel  = (MODE == 0 && diff[PW]) ? '0 : mag;
    assign neg_load = (MODE == 1) && diff[PW];
    assign num_load = NW'(mag_sel) * NW'(SCALE);

    // One restoring-division step: dividend bits shift out of quo_reg MSB-first
    // while quotient bits shift in at the LSB.
    logic [RW-1:0]  rem_shift;
    logic [RW-1:0]  den_ext;
    logic           quo_bit;
    logic [RW-1:0]  rem_next;
    logic [NW-1:0]  quo_next;
    logic [QW-1:0]  sat_q;
    logic           last_step;
    logic           den_zero;

    assign rem_shift = {rem_reg[RW-2:0], quo_reg[NW-1]};
    assign den_ext   = {1'b0, den_reg};
    assign quo_bit   = (rem_shift >= den_ext);
    assign rem_next  = quo_bit ? (rem_shift - den_ext) : rem_shift;
    assign quo_next  = {quo_reg[NW-2:0], quo_bit};
    assign last_step = (step_reg == SW'(NW - 1));
    assign den_zero  = (den_reg == '0);

    always_comb begin
        sat_q = quo_next[QW-1:0];
        if (|quo_next[NW-1:QW])
            sat_q = '1;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pls && start)     state_next = LOAD;
            LOAD:    if (pls)              state_next = DIV;
            DIV:     if (pls && last_step) state_next = DONE;
            DONE:                          state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_reg     <= '0;
            den_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            neg_reg      <= 1'b0;
            indx_cal_reg <= '0;
            indx_neg_reg <= 1'b0;
            div_err_reg  <= 1'b0;
        end else begin
            if (state_reg == LOAD && pls) begin
                den_reg  <= den_load;
                quo_reg  <= num_load;
                rem_reg  <= '0;
                step_reg <= '0;
                neg_reg  <= neg_load;
            end
            if (state_reg == DIV && pls) begin
                rem_reg  <= rem_next;
                quo_reg  <= quo_next;
                step_reg <= step_reg + SW'(1);
                if (last_step) begin
                    // A zero denominator yields all-ones quotient bits; report 0 instead
                    indx_cal_reg <= den_zero ? '0 : sat_q;
                    indx_neg_reg <= den_zero ? 1'b0 : neg_reg;
                    div_err_reg  <= den_zero;
                end
            end
        end
    end

    assign busy     = (state_reg != IDLE);
    assign indx_dn  = (state_reg == DONE);
    assign indx_cal = indx_cal_reg;
    assign indx_neg = indx_neg_reg;
    assign div_err  = div_err_reg;

endmodule

// File: tb/tb_am_indx_engine.sv
// Randomized self-checking bench for am_indx_engine: three parameterisations
// share stimulus and are compared with an arithmetic reference model.
module tb_am_indx_engine;

    logic        clk = 1'b0;
    logic        rst, pls, start, up_dni;
    logic [11:0] pp_t2b, pp_b2t;

    logic       busy0, dn0, neg0, err0;
    logic [7:0] cal0;
    logic       busy1, dn1, neg1, err1;
    logic [7:0] cal1;
    logic       busy2, dn2, neg2, err2;
    logic [5:0] cal2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    am_indx_engine #(.PW(12), .QW(8), .SCALE(100), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .pls(pls), .start(start), .up_dni(up_dni),
        .pp_t2b(pp_t2b), .pp_b2t(pp_b2t), .busy(busy0), .indx_dn(dn0),
        .indx_cal(cal0), .indx_neg(neg0), .div_err(err0));

    am_indx_engine #(.PW(12), .QW(8), .SCALE(100), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .pls(pls), .start(start), .up_dni(up_dni),
        .pp_t2b(pp_t2b), .pp_b2t(pp_b2t), .busy(busy1), .indx_dn(dn1),
        .indx_cal(cal1), .indx_neg(neg1), .div_err(err1));

    am_indx_engine #(.PW(12), .QW(6), .SCALE(100), .MODE(0)) dut2 (
        .clk(clk), .rst(rst), .pls(pls), .start(start), .up_dni(up_dni),
        .pp_t2b(pp_t2b), .pp_b2t(pp_b2t), .busy(busy2), .indx_dn(dn2),
        .indx_cal(cal2), .indx_neg(neg2), .div_err(err2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: index = |d| * 100 / (t2b + b2t), clamped to QW bits
    function automatic void model(input int t, input int b, input int up, input int mode,
                                  input int qw, output int cal, output int neg, output int err);
        int d, den, q;
        d   = up ? (t - b) : (b - t);
        den = t + b;
        cal = 0; neg = 0; err = 0;
        if (den == 0) begin
            err = 1;
        end else if (d < 0 && mode == 0) begin
            cal = 0;
        end else begin
            q   = ((d < 0) ? -d : d) * 100 / den;
            cal = (q > (1 << qw) - 1) ? (1 << qw) - 1 : q;
            neg = (mode == 1 && d < 0) ? 1 : 0;
        end
    endfunction

    task automatic run_calc(input int t, input int b, input int up, input int tog);
        int c0, n0, e0, c1, n1, e1, c2, n2, e2;
        int cyc, en_cnt, busy_ok, seen;
        logic pls_used;
        model(t, b, up, 0, 8, c0, n0, e0);
        model(t, b, up, 1, 8, c1, n1, e1);
        model(t, b, up, 0, 6, c2, n2, e2);
        @(negedge clk);
        pp_t2b = 12'(t); pp_b2t = 12'(b); up_dni = 1'(up);
        start = 1'b1; pls = 1'b1;
        cyc = 0; en_cnt = 0; busy_ok = 1; seen = 0;
        while (cyc < 200) begin
            pls_used = pls;
            @(posedge clk); #1;
            cyc++;
            if (pls_used) en_cnt++;
            start = 1'b0;
            if (dn0) begin
                seen = 1;
                break;
            end
            if (!busy0) busy_ok = 0;
            // Operands are already captured; scramble inputs to prove they are ignored
            if (en_cnt >= 2) begin
                pp_t2b = 12'($urandom_range(0, 4095));
                pp_b2t = 12'($urandom_range(0, 4095));
                up_dni = 1'($urandom);
            end
            pls = tog ? ~pls : 1'b1;
        end
        $display("[TB] t2b=%0d b2t=%0d up=%0d tog=%0d edges=%0d cal=%0d/%0d/%0d exp=%0d/%0d/%0d",
                 t, b, up, tog, cyc, cal0, cal1, cal2, c0, c1, c2);
        check("done_seen", 32'(seen), 1);
        if (!tog) check("latency", 32'(cyc), 22);
        check("enabled_edges", 32'(en_cnt), 22);
        check("busy_during", 32'(busy_ok), 1);
        check("dn_mode1", 32'(dn1), 1);
        check("dn_qw6", 32'(dn2), 1);
        check("cal_m0", 32'(cal0), 32'(c0));
        check("neg_m0", 32'(neg0), 32'(n0));
        check("err_m0", 32'(err0), 32'(e0));
        check("cal_m1", 32'(cal1), 32'(c1));
        check("neg_m1", 32'(neg1), 32'(n1));
        check("err_m1", 32'(err1), 32'(e1));
        check("cal_qw6", 32'(cal2), 32'(c2));
        check("err_qw6", 32'(err2), 32'(e2));
        @(posedge clk); #1;
        check("dn_pulse_end", 32'(dn0), 0);
        check("busy_after", 32'(busy0), 0);
        check("cal_hold", 32'(cal0), 32'(c0));
        pls = 1'b1;
    endtask

    initial begin
        int cyc, dn_cnt, gap;
        rst = 1'b1; pls = 1'b0; start = 1'b0; up_dni = 1'b0;
        pp_t2b = '0; pp_b2t = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy0), 0);
        check("rst_dn", 32'(dn0), 0);
        check("rst_cal", 32'(cal0), 0);
        check("rst_neg", 32'(neg1), 0);
        check("rst_err", 32'(err0), 0);
        rst = 1'b0;

        run_calc(300, 100, 1, 0);
        run_calc(100, 300, 1, 0);
        run_calc(0, 0, 1, 0);
        run_calc(4095, 0, 1, 0);
        run_calc(100, 300, 0, 0);
        run_calc(300, 100, 1, 1);

        // Reset asserted so the 10th DIV step edge is a reset edge
        @(negedge clk);
        pp_t2b = 12'd300; pp_b2t = 12'd100; up_dni = 1'b1; start = 1'b1; pls = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy0), 0);
        check("midrst_dn", 32'(dn0), 0);
        check("midrst_cal", 32'(cal0), 0);
        check("midrst_cal_m1", 32'(cal1), 0);
        check("midrst_err", 32'(err0), 0);
        dn_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (dn0) dn_cnt++;
        end
        check("midrst_no_dn", 32'(dn_cnt), 0);
        $display("[TB] mid-DIV reset: busy=%0d cal=%0d dn_after=%0d", busy0, cal0, dn_cnt);
        run_calc(300, 100, 1, 0);

        for (int k = 0; k < 30; k++) begin
            int t, b;
            t = (k % 7 == 0) ? 0 : int'($urandom_range(0, 4095));
            b = (k % 5 == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4095));
            if (k == 14) b = 0;
            run_calc(t, b, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        // start held high: second calculation follows DONE -> IDLE -> LOAD
        @(negedge clk);
        pp_t2b = 12'd300; pp_b2t = 12'd100; up_dni = 1'b1; start = 1'b1; pls = 1'b1;
        cyc = 0;
        while (cyc < 100 && !dn0) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_first", 32'(dn0), 1);
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
        end while (gap < 100 && !dn0);
        start = 1'b0;
        $display("[TB] back-to-back: gap=%0d cal=%0d", gap, cal0);
        check("b2b_gap", 32'(gap), 23);
        check("b2b_cal", 32'(cal0), 50);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
